// File: rtl/uart_hex_tx.sv
// Formats a latched word as uppercase ASCII hex + CR LF into the UART TX FIFO.
// Define UART_HEX_PREFIX_EN to prepend "0x" to every line.
module uart_hex_tx #(
  parameter int DATA_W = 16
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              tx_full,
  output logic              write_uart,
  output logic [7:0]        write_data,
  output logic              busy,
  output logic              done
);

  localparam int N  = DATA_W / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

`ifdef UART_HEX_PREFIX_EN
  typedef enum logic [2:0] {
    IDLE, PFX0, PFX1, DIGIT, CR, LF, DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, DIGIT, CR, LF, DONE
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] word_sh;
  logic [3:0]        nib;
  logic [7:0]        hex_char;

  assign word_sh = word_q >> {cnt_q, 2'b00};
  assign nib     = word_sh[3:0];

  always_comb begin
    hex_char = 8'h00;
    unique case (1'b1)
      (nib <  4'd10): hex_char = 8'h30 + {4'h0, nib};
      (nib >= 4'd10): hex_char = 8'h37 + {4'h0, nib};
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

  // Emitting states advance only on a cycle that actually writes a byte.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    write_uart = 1'b0;
    write_data = 8'h00;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          word_d  = data_in;
          cnt_d   = CW'(N - 1);
`ifdef UART_HEX_PREFIX_EN
          state_d = PFX0;
`else
          state_d = DIGIT;
`endif
        end
      end
`ifdef UART_HEX_PREFIX_EN
      PFX0: begin
        write_data = 8'h30;
        write_uart = ~tx_full;
        if (!tx_full) state_d = PFX1;
      end
      PFX1: begin
        write_data = 8'h78;
        write_uart = ~tx_full;
        if (!tx_full) state_d = DIGIT;
      end
`endif
      DIGIT: begin
        write_data = hex_char;
        write_uart = ~tx_full;
        if (!tx_full) begin
          if (cnt_q == '0) state_d = CR;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      CR: begin
        write_data = 8'h0D;
        write_uart = ~tx_full;
        if (!tx_full) state_d = LF;
      end
      LF: begin
        write_data = 8'h0A;
        write_uart = ~tx_full;
        if (!tx_full) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_hex_tx.sv
// Randomized bench for uart_hex_tx against a byte-queue line model.
// Follows UART_HEX_PREFIX_EN the same way the design does.
module tb_uart_hex_tx;

  localparam int DATA_W = 16;
  localparam int N      = DATA_W / 4;
`ifdef UART_HEX_PREFIX_EN
  localparam bit PFX = 1'b1;
`else
  localparam bit PFX = 1'b0;
`endif

  logic              clk_100MHz = 1'b0;
  logic              reset;
  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              tx_full;
  logic              write_uart;
  logic [7:0]        write_data;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;
  byte unsigned exp_q[$];

  uart_hex_tx #(.DATA_W(DATA_W)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .start      (start),
    .data_in    (data_in),
    .tx_full    (tx_full),
    .write_uart (write_uart),
    .write_data (write_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Expected line: optional "0x", N hex digits MSB first, CR, LF.
  function automatic void build(input logic [DATA_W-1:0] d);
    int n;
    exp_q.delete();
    if (PFX) begin
      exp_q.push_back(8'h30);
      exp_q.push_back(8'h78);
    end
    for (int i = N - 1; i >= 0; i--) begin
      n = int'((d >> (4 * i)) & 16'hF);
      if (n < 10) exp_q.push_back(byte'(48 + n));
      else        exp_q.push_back(byte'(65 + n - 10));
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  task automatic run_msg(input logic [DATA_W-1:0] d, input int stall_pct,
                         input int stall_lo, input int stall_hi,
                         input bit stray, input int exp_done);
    int cyc;
    int idx;
    build(d);
    @(posedge clk_100MHz);
    #1;
    start   = 1'b1;
    data_in = d;
    tx_full = ($urandom_range(0, 99) < stall_pct);
    @(posedge clk_100MHz);
    cyc = 1;
    idx = 0;
    while (idx < exp_q.size() && cyc < 200) begin
      #1;
      start   = stray && ($urandom_range(0, 3) == 0);
      data_in = DATA_W'($urandom);
      tx_full = (cyc >= stall_lo && cyc <= stall_hi) ||
                ($urandom_range(0, 99) < stall_pct);
      @(negedge clk_100MHz);
      chk("busy", busy, 1);
      chk("done_early", done, 0);
      chk("write_uart", write_uart, !tx_full);
      chk("write_data", write_data, exp_q[idx]);
      if (write_uart) idx++;
      @(posedge clk_100MHz);
      cyc++;
    end
    chk("timeout", idx, exp_q.size());
    #1;
    start   = stray;
    data_in = DATA_W'($urandom);
    tx_full = 1'($urandom);
    @(negedge clk_100MHz);
    chk("done", done, 1);
    chk("busy_done", busy, 0);
    chk("write_done", write_uart, 0);
    if (exp_done >= 0) chk("done_cycle", cyc, exp_done);
    @(posedge clk_100MHz);
    #1;
    start   = 1'b0;
    tx_full = 1'b0;
    @(negedge clk_100MHz);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_write", write_uart, 0);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    tx_full = 1'b0;
    data_in = '0;
    repeat (3) @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    chk("rst_write", write_uart, 0);
    chk("rst_data", write_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk_100MHz);
    #1 reset = 1'b0;

    run_msg(16'hA5C3, 0, 0, -1, 1'b0, N + 2 * int'(PFX) + 3);
    run_msg(16'h0000, 0, 0, -1, 1'b0, N + 2 * int'(PFX) + 3);
    run_msg(16'hFFFF, 0, 0, -1, 1'b0, N + 2 * int'(PFX) + 3);
    run_msg(16'h1234, 0, 3, 5, 1'b0, N + 2 * int'(PFX) + 6);
    run_msg(16'h1234, 0, 0, -1, 1'b1, N + 2 * int'(PFX) + 3);
    run_msg(16'hBEEF, 0, 0, -1, 1'b0, N + 2 * int'(PFX) + 3);

    // Abort a line partway through with reset.
    @(posedge clk_100MHz);
    #1;
    start   = 1'b1;
    data_in = 16'h1234;
    @(posedge clk_100MHz);
    #1 start = 1'b0;
    repeat (3) @(posedge clk_100MHz);
    #1 reset = 1'b1;
    @(posedge clk_100MHz);
    #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_100MHz);
      chk("abort_busy", busy, 0);
      chk("abort_write", write_uart, 0);
      chk("abort_done", done, 0);
    end
    run_msg(16'h9A0F, 0, 0, -1, 1'b0, N + 2 * int'(PFX) + 3);

    for (int t = 0; t < 20; t++)
      run_msg(DATA_W'($urandom), 30, 0, -1, 1'b1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
